mpu_seq: RTL and testbench
==========================

# mpu_seq

Instruction sequencer for the 8-bit MPU core. Sits between the SFR block (PC/SP), the synchronous 13-bit-address instruction ROM and the ID decoder, and fixes instruction timing: ROM address issue, the ROM read-latency wait, presenting one instruction to ID, then one PC/SP update. It handles sequential flow, branch, call/return with stack-pointer management, stall, halt and stack-fault detection.

## Interface
- PC_W, 13, PC / ROM address width
- SP_W, 8, stack pointer width
- RESET_PC, 13'h0000, first fetch address after `run` rises from IDLE
- SP_INIT, 8'hFF, empty-stack SP value
- sys_clk  in  1  sole clock, rising edge
- sys_res_n  in  1  asynchronous, active-low reset
- run  in  1  start/enable; level
- stall  in  1  ID back-pressure; honoured only in DECODE
- code  in  32  ROM douta
- rom_addr  out  PC_W  ROM addra
- instr  out  32  instruction to ID
- instr_valid  out  1  instr valid this cycle
- br_req, call_req, ret_req, halt_req  in  1 each  ID control, sampled in DECODE only
- br_tgt  in  PC_W  branch/call target
- PC_r  in  PC_W  current PC from SFR
- SP_r  in  SP_W  current SP from SFR
- PC_w  out  PC_W; PC_wen  out  1  PC write to SFR
- SP_w  out  SP_W; SP_wen  out  1  SP write to SFR
- stk_push, stk_pop  out  1 each  stack RAM strobes
- stk_wdata  out  PC_W  return address to push
- stk_rdata  in  PC_W  stack top, combinational, valid while stk_pop
- halted  out  1  in HALT
- seq_err  out  1  sticky stack fault

## Operation
- States: IDLE, FETCH, WAIT, DECODE, UPDATE, HALT.
- IDLE: `run`=1 → PC_w=RESET_PC, SP_w=SP_INIT, PC_wen=SP_wen=1 for one cycle → FETCH.
- FETCH: rom_addr=PC_r → WAIT. rom_addr holds the last issued address in every other state.
- WAIT: ROM latency cycle, with `code` valid at its end → DECODE. instr registered from `code`.
- DECODE: instr_valid=1. If stall=1, stay and hold instr. Otherwise sample controls with priority halt > ret > call > br > sequential → UPDATE. Outputs for UPDATE are registered here.
- UPDATE: exactly one PC_wen pulse, then → FETCH. Cases:
  - Sequential: PC_w=PC_r+1, modulo 2^PC_W (1FFF wraps to 0000).
  - br: PC_w=br_tgt.
  - call: stk_push=1, stk_wdata=PC_r+1 (wrapped), PC_w=br_tgt, SP_w=SP_r−1, SP_wen=1.
  - ret: stk_pop=1, PC_w=stk_rdata, SP_w=SP_r+1, SP_wen=1.
  - halt: no PC/SP write → HALT.
- Stack faults:
  - call with SP_r==0 (overflow) → seq_err=1, no push, no writes → HALT.
  - ret with SP_r==SP_INIT (underflow) → seq_err=1, no pop, no writes → HALT.
- HALT: halted=1. `run`=0 → IDLE. seq_err stays set until reset.
- `run`=0 in FETCH/WAIT/DECODE/UPDATE: the current instruction completes, then IDLE instead of FETCH.

## Timing
- 4 cycles per instruction without stall: FETCH, WAIT, DECODE, UPDATE. Each stall cycle adds one.
- ROM read latency is fixed at 1 cycle; `code` is sampled at the end of WAIT.
- PC_wen, SP_wen, stk_push and stk_pop are single-cycle pulses.
- PC_r reflects the new value in FETCH, the cycle after UPDATE.
- Reset values: state=IDLE; rom_addr=0; instr=0; instr_valid=0; PC_w=0; PC_wen=0; SP_w=0; SP_wen=0; stk_push=0; stk_pop=0; stk_wdata=0; halted=0; seq_err=0.
- Reset asserted mid-instruction: immediate return to IDLE, no partial PC/SP write completes.
- Controls are ignored outside DECODE, and also while stall=1.

## Structure
- Package mpu_seq_pkg holds:
  - seq_state_t enum
  - PC_W, SP_W
  - ctl_sel_t enum {SEQ, BR, CALL, RET, HALT}
  - next-PC and wrap helper function
- Single module, no sub-module. The next-PC/SP decision is one combinational process.
- Top-level integration: rom_addr replaces the direct PC_r→addra connection.

## Test plan
- Reset with run=1 → IDLE→FETCH: PC_wen with PC_w=0000, SP_w=FF. ROM words at 0,1,2 appear on instr with instr_valid every 4th cycle; PC sequence 0,1,2.
- br_req at PC=0005 with br_tgt=1000 → PC_w=1000 and next rom_addr=1000. PC=1FFF with no control → PC_w=0000.
- call at PC=0010 with tgt=0200 and SP=FF → push 0011, SP_w=FE. A later ret with stk_rdata=0011 → PC_w=0011, SP_w=FF.
- call with SP=00 → seq_err=1, halted=1, no push, no PC_wen. ret with SP=FF → same response.
- stall held 3 cycles in DECODE → instr_valid held 3 cycles with instr stable. A br_req pulsed during the stall is ignored; the instruction takes 7 cycles total.
- sys_res_n low during WAIT → all outputs at reset values asynchronously. halt_req, then run low → IDLE, halted=0.

Source files
------------

// File: rtl/mpu_seq_pkg.sv
// mpu_seq_pkg: shared widths, state/control enums and PC helpers for the MPU instruction sequencer
package mpu_seq_pkg;
  localparam int PC_W = 13;
  localparam int SP_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_UPDATE, S_HALT} seq_state_t;
  typedef enum logic [2:0] {SEQ, BR, CALL, RET, HALT} ctl_sel_t;
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction
  function automatic logic [PC_W-1:0] next_pc(input ctl_sel_t sel, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
    return (sel == BR || sel == CALL) ? tgt : pc_inc(pc);
  endfunction
endpackage

// File: rtl/mpu_seq.sv
// mpu_seq: fetch/wait/decode/update sequencer driving ROM address, ID instruction and PC/SP/stack updates
module mpu_seq
  import mpu_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [SP_W-1:0] SP_INIT  = '1
) (
  input  logic            sys_clk,
  input  logic            sys_res_n,
  input  logic            run,
  input  logic            stall,
  input  logic [31:0]     code,
  output logic [PC_W-1:0] rom_addr,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            br_req,
  input  logic            call_req,
  input  logic            ret_req,
  input  logic            halt_req,
  input  logic [PC_W-1:0] br_tgt,
  input  logic [PC_W-1:0] PC_r,
  input  logic [SP_W-1:0] SP_r,
  output logic [PC_W-1:0] PC_w,
  output logic            PC_wen,
  output logic [SP_W-1:0] SP_w,
  output logic            SP_wen,
  output logic            stk_push,
  output logic            stk_pop,
  output logic [PC_W-1:0] stk_wdata,
  input  logic [PC_W-1:0] stk_rdata,
  output logic            halted,
  output logic            seq_err
);
  seq_state_t state;
  ctl_sel_t sel;
  logic fault, stop_q;
  logic [PC_W-1:0] pc_nx, pc_q, addr_q;
  logic [SP_W-1:0] sp_nx;
  always_comb begin
    sel = halt_req ? HALT : ret_req ? RET : call_req ? CALL : br_req ? BR : SEQ;
    fault = (sel == CALL && SP_r == '0) || (sel == RET && SP_r == SP_INIT);
    pc_nx = next_pc(sel, PC_r, br_tgt);
    sp_nx = sel == CALL ? SP_r - SP_W'(1) : SP_r + SP_W'(1);
  end
  assign rom_addr = state == S_FETCH ? (PC_wen ? pc_q : PC_r) : addr_q;
  assign PC_w = stk_pop ? stk_rdata : pc_q;
  always_ff @(posedge sys_clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      pc_q        <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      PC_wen      <= 1'b0;
      SP_w        <= '0;
      SP_wen      <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_wdata   <= '0;
      halted      <= 1'b0;
      seq_err     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      PC_wen      <= 1'b0;
      SP_wen      <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        S_IDLE: if (run) begin
          state  <= S_FETCH;
          pc_q   <= RESET_PC;
          PC_wen <= 1'b1;
          SP_w   <= SP_INIT;
          SP_wen <= 1'b1;
        end
        S_FETCH: begin
          addr_q <= rom_addr;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          instr       <= code;
          instr_valid <= 1'b1;
          state       <= S_DECODE;
        end
        S_DECODE: if (stall) instr_valid <= 1'b1;
        else begin
          state   <= S_UPDATE;
          stop_q  <= sel == HALT || fault;
          seq_err <= seq_err | fault;
          if (sel != HALT && !fault) begin
            PC_wen   <= 1'b1;
            pc_q     <= pc_nx;
            SP_wen   <= sel == CALL || sel == RET;
            stk_push <= sel == CALL;
            stk_pop  <= sel == RET;
            if (sel == CALL || sel == RET) SP_w <= sp_nx;
            if (sel == CALL) stk_wdata <= pc_inc(PC_r);
          end
        end
        S_UPDATE: begin
          if (stk_pop) pc_q <= stk_rdata;
          halted <= stop_q;
          state  <= stop_q ? S_HALT : run ? S_FETCH : S_IDLE;
        end
        S_HALT: if (!run) begin
          halted <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_seq.sv
// tb_mpu_seq: randomized and directed bench for mpu_seq against an instruction-level model
module tb_mpu_seq;
  import mpu_seq_pkg::*;
  localparam int NPC = 1 << PC_W;
  localparam int SPI = 255;
  logic sys_clk = 0, sys_res_n = 0, run = 0, stall = 0;
  logic br_req = 0, call_req = 0, ret_req = 0, halt_req = 0;
  logic [31:0] code = 0, instr;
  logic [PC_W-1:0] rom_addr, br_tgt = 0, PC_r = 0, PC_w, stk_wdata, stk_rdata;
  logic [SP_W-1:0] SP_r = 0, SP_w;
  logic instr_valid, PC_wen, SP_wen, stk_push, stk_pop, halted, seq_err;
  logic [31:0] rom [NPC];
  logic [PC_W-1:0] sram [256];
  int n_cmp = 0, n_err = 0, cyc = 0, t_last = 0, t0 = 0;
  int m_pc = 0, m_sp = SPI, n_pop = 0;
  bit m_err = 0, m_halted = 0, stopped = 0;
  int q_pcw[$], q_spw[$], q_push[$], m_stack[$];
  logic [PC_W-1:0] cap_pcw, cap_wdata, cap_addr;
  logic [SP_W-1:0] cap_spw;
  logic cap_pcwen, cap_push, cap_pop;

  mpu_seq dut (
    .sys_clk(sys_clk), .sys_res_n(sys_res_n), .run(run), .stall(stall), .code(code),
    .rom_addr(rom_addr), .instr(instr), .instr_valid(instr_valid),
    .br_req(br_req), .call_req(call_req), .ret_req(ret_req), .halt_req(halt_req),
    .br_tgt(br_tgt), .PC_r(PC_r), .SP_r(SP_r), .PC_w(PC_w), .PC_wen(PC_wen),
    .SP_w(SP_w), .SP_wen(SP_wen), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .halted(halted), .seq_err(seq_err)
  );

  always #5 sys_clk = ~sys_clk;

  // environment: synchronous ROM, SFR registers and stack RAM
  assign stk_rdata = sram[SP_r + 8'd1];
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    code <= rom[rom_addr];
    if (PC_wen) PC_r <= PC_w;
    if (SP_wen) SP_r <= SP_w;
    if (stk_push) sram[SP_r] <= stk_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model's expected instruction and strobe queues
  always @(negedge sys_clk) if (sys_res_n) begin
    if (instr_valid) begin
      chk("instr", instr, rom[m_pc]);
      chk("rom_addr", {19'd0, rom_addr}, m_pc);
    end
    if (PC_wen) begin
      if (q_pcw.size() == 0) chk("PC_wen_unexpected", {31'd0, PC_wen}, 0);
      else chk("PC_w", {19'd0, PC_w}, q_pcw.pop_front());
    end
    if (SP_wen) begin
      if (q_spw.size() == 0) chk("SP_wen_unexpected", {31'd0, SP_wen}, 0);
      else chk("SP_w", {24'd0, SP_w}, q_spw.pop_front());
    end
    if (stk_push) begin
      if (q_push.size() == 0) chk("stk_push_unexpected", {31'd0, stk_push}, 0);
      else chk("stk_wdata", {19'd0, stk_wdata}, q_push.pop_front());
    end
    if (stk_pop) begin
      if (n_pop == 0) chk("stk_pop_unexpected", {31'd0, stk_pop}, 0);
      else n_pop--;
    end
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("seq_err", {31'd0, seq_err}, {31'd0, m_err});
  end

  task automatic step;
    @(negedge sys_clk);
    #1;
  endtask

  task automatic launch;
    run = 1;
    m_pc = 0;
    m_sp = SPI;
    m_stack.delete();
    q_pcw.push_back(0);
    q_spw.push_back(SPI);
    step;
    cap_addr = rom_addr;
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!instr_valid && n < 12) begin
      step;
      n++;
    end
    chk("fetch_latency", n, 2);
    if (!instr_valid) begin
      $display("FAIL instr_valid_timeout: got 0 expected 1");
      $fatal(1);
    end
    t_last = cyc;
  endtask

  task automatic exec(input int k, input bit h, input bit r, input bit c, input bit b, input int tgt, input bit run_after);
    bit flt;
    int npc;
    wait_valid;
    for (int i = 0; i < k; i++) begin
      stall = 1;
      br_req = 1;
      call_req = 1'($urandom);
      ret_req = 1'($urandom);
      halt_req = 1'($urandom);
      br_tgt = PC_W'($urandom);
      step;
      chk("stall_valid", {31'd0, instr_valid}, 1);
    end
    stall = 0;
    halt_req = h;
    ret_req = r;
    call_req = c;
    br_req = b;
    br_tgt = PC_W'(tgt);
    flt = !h && ((r && m_sp == SPI) || (!r && c && m_sp == 0));
    stopped = h || flt;
    if (flt) m_err = 1;
    if (!stopped) begin
      if (r) begin
        npc = m_stack.pop_back();
        m_sp++;
        q_spw.push_back(m_sp);
        n_pop++;
      end else if (c) begin
        q_push.push_back((m_pc + 1) % NPC);
        m_stack.push_back((m_pc + 1) % NPC);
        npc = tgt % NPC;
        m_sp--;
        q_spw.push_back(m_sp);
      end else if (b) npc = tgt % NPC;
      else npc = (m_pc + 1) % NPC;
      q_pcw.push_back(npc);
      m_pc = npc;
    end
    step;
    cap_pcw = PC_w;
    cap_pcwen = PC_wen;
    cap_spw = SP_w;
    cap_push = stk_push;
    cap_wdata = stk_wdata;
    cap_pop = stk_pop;
    {halt_req, ret_req, call_req, br_req} = '0;
    run = run_after;
    if (stopped) m_halted = 1;
    if (stopped) begin
      step;
      chk("halted_in_halt", {31'd0, halted}, 1);
      run = 0;
      m_halted = 0;
      step;
      launch;
    end else if (!run_after) begin
      step;
      launch;
    end else begin
      step;
      cap_addr = rom_addr;
    end
  endtask

  task automatic chk_reset_vals;
    chk("rst_rom_addr", {19'd0, rom_addr}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 0);
    chk("rst_PC_w", {19'd0, PC_w}, 0);
    chk("rst_PC_wen", {31'd0, PC_wen}, 0);
    chk("rst_SP_w", {24'd0, SP_w}, 0);
    chk("rst_SP_wen", {31'd0, SP_wen}, 0);
    chk("rst_stk_push", {31'd0, stk_push}, 0);
    chk("rst_stk_pop", {31'd0, stk_pop}, 0);
    chk("rst_stk_wdata", {19'd0, stk_wdata}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_seq_err", {31'd0, seq_err}, 0);
  endtask

  initial begin
    foreach (rom[i]) rom[i] = $urandom;
    foreach (sram[i]) sram[i] = '0;
    repeat (3) step;
    chk_reset_vals;
    sys_res_n = 1;
    launch;
    for (int i = 0; i < 5; i++) exec(0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc5", {19'd0, cap_pcw}, 'h5);
    exec(0, 0, 0, 0, 1, 'h1000, 1);
    chk("br_pc", {19'd0, cap_pcw}, 'h1000);
    chk("br_rom_addr", {19'd0, cap_addr}, 'h1000);
    exec(0, 0, 0, 0, 1, 'h1FFF, 1);
    exec(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_pc", {19'd0, cap_pcw}, 'h0);
    exec(0, 0, 0, 0, 1, 'h0010, 1);
    exec(0, 0, 0, 1, 0, 'h0200, 1);
    chk("call_push", {31'd0, cap_push}, 1);
    chk("call_wdata", {19'd0, cap_wdata}, 'h0011);
    chk("call_sp", {24'd0, cap_spw}, 'hFE);
    chk("call_pc", {19'd0, cap_pcw}, 'h0200);
    exec(0, 0, 1, 0, 0, 0, 1);
    chk("ret_pop", {31'd0, cap_pop}, 1);
    chk("ret_pc", {19'd0, cap_pcw}, 'h0011);
    chk("ret_sp", {24'd0, cap_spw}, 'hFF);
    exec(3, 0, 0, 0, 0, 0, 1);
    t0 = t_last;
    chk("stall_pc", {19'd0, cap_pcw}, 'h0012);
    exec(0, 0, 0, 0, 0, 0, 1);
    chk("stall_len", t_last - t0, 7);
    for (int i = 0; i < 255; i++) exec(0, 0, 0, 1, 0, int'($urandom_range(0, NPC - 1)), 1);
    exec(0, 0, 0, 1, 0, 'h0300, 1);
    chk("ovf_no_pcwen", {31'd0, cap_pcwen}, 0);
    chk("ovf_no_push", {31'd0, cap_push}, 0);
    chk("ovf_err", {31'd0, seq_err}, 1);
    exec(0, 0, 1, 0, 0, 0, 1);
    chk("udf_no_pcwen", {31'd0, cap_pcwen}, 0);
    chk("udf_no_pop", {31'd0, cap_pop}, 0);
    exec(0, 1, 0, 0, 0, 0, 1);
    chk("halt_no_pcwen", {31'd0, cap_pcwen}, 0);
    for (int i = 0; i < 300; i++)
      exec(($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0,
           $urandom % 40 == 0, $urandom % 5 == 0, $urandom % 5 == 0, $urandom % 4 == 0,
           int'($urandom_range(0, NPC - 1)), $urandom % 30 != 0);
    step;
    chk("wait_no_valid", {31'd0, instr_valid}, 0);
    chk("err_sticky", {31'd0, seq_err}, 1);
    sys_res_n = 0;
    q_pcw.delete();
    q_spw.delete();
    q_push.delete();
    n_pop = 0;
    m_err = 0;
    m_halted = 0;
    #1;
    chk_reset_vals;
    step;
    step;
    sys_res_n = 1;
    launch;
    for (int i = 0; i < 20; i++) exec(0, 0, $urandom % 4 == 0, $urandom % 4 == 0, $urandom % 3 == 0, int'($urandom_range(0, NPC - 1)), 1);
    wait_valid;
    chk("q_pcw_left", q_pcw.size(), 0);
    chk("q_spw_left", q_spw.size(), 0);
    chk("q_push_left", q_push.size(), 0);
    chk("pop_left", n_pop, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
